seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//   Reverse path of the on-board 7-segment display driver. Samples an
//   active-low 7-segment bus, waits for it to hold steady, decodes the pattern
//   back to a 3-bit digit 0..7 and hands it out over a valid/ready interface.
//   Used by self-check and loopback logic to read back what the display shows.
// PARAMETERS
//   STABLE_CYCLES  4  consecutive identical enabled samples needed to accept (>=1)
//   CNT_W          3  stability counter width; must hold STABLE_CYCLES
// PORTS
//   clk        in   1  clock, all state updates on rising edge
//   rst_n      in   1  asynchronous active-low reset
//   seg_in     in   7  active-low segments {a,b,c,d,e,f,g}, bit6=a
//   seg_en     in   1  sample qualifier; seg_in is ignored while low
//   out_valid  out  1  decoded result available
//   out_ready  in   1  consumer accepts result when high together with out_valid
//   out_digit  out  3  decoded digit; 0 when out_err=1
//   out_err    out  1  accepted pattern is not a legal digit 0..7
//   busy       out  1  FSM is not in IDLE
// BEHAVIOUR
//   Legal patterns (hex, active-low): 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F.
//     Any other value, including 7F (blank), is illegal.
//   Reset: FSM=IDLE, cnt=0, cap=7'h7F; out_valid=0, out_digit=0, out_err=0, busy=0.
//   FSM states: IDLE, SETTLE, VALID, WAIT_CHG.
//   IDLE: on seg_en=1, cap<=seg_in and cnt<=1. Go to SETTLE, or go straight to
//     VALID if STABLE_CYCLES==1.
//   SETTLE, per edge:
//     seg_en=0                 -> IDLE, cnt<=0
//     seg_en=1, seg_in!=cap    -> cap<=seg_in, cnt<=1, stay in SETTLE
//     seg_en=1, seg_in==cap    -> cnt<=cnt+1; on the edge where cnt+1 ==
//                                 STABLE_CYCLES, go to VALID
//   Entry to VALID registers out_digit/out_err from cap and sets out_valid=1 on
//     the same edge. Latency from the first of S constant enabled samples is S
//     edges.
//   VALID: out_valid, out_digit and out_err stay stable until out_valid &&
//     out_ready. seg_in and seg_en are ignored here; there is no overrun capture.
//   Handshake edge: out_valid<=0.
//     seg_en=1, seg_in!=cap -> SETTLE, cap<=seg_in, cnt<=1
//     otherwise             -> WAIT_CHG
//   WAIT_CHG: blocks repeat reporting of the same pattern.
//     seg_en=0              -> IDLE
//     seg_en=1, seg_in!=cap -> SETTLE, cap<=seg_in, cnt<=1
//     otherwise             -> stay in WAIT_CHG
//   out_ready is don't-care outside VALID.
//   busy = (state != IDLE); it is registered state, not a separate flop.
//   cnt saturates and never wraps. CNT_W too narrow for STABLE_CYCLES is a
//     configuration error, flagged in simulation only.
//   Asynchronous reset mid-operation: all state returns to reset values at once.
//     A pending result is discarded. Nothing is emitted until a fresh full
//     settle completes after rst_n rises.
// TESTING
//   1 seg_en=1, seg_in=12 held, out_ready=1 -> out_valid high for 1 cycle after
//     edge 4, out_digit=2, out_err=0; no second pulse while held.
//   2 seg_in 4F for 2 edges then 0F held -> count restarts; out_valid after 4
//     edges of 0F, out_digit=7.
//   3 seg_in=7F held 4 edges -> out_valid=1, out_err=1, out_digit=0.
//   4 out_ready=0 for 10 cycles after valid (digit 5, 24), seg_in changed to 01
//     -> outputs hold 5 unchanged; after ready, result 0 follows 4 edges later.
//   5 stable 06 reported, then seg_en low 1 cycle, 06 again for 4 edges -> second
//     out_valid with out_digit=3 (IDLE re-arm).
//   6 rst_n low during SETTLE (cnt=3) and during VALID -> outputs 0 at once, no
//     stale result after release; STABLE_CYCLES=1 build: valid 1 edge after sample.

Source files
------------

// File: rtl/seg7_capture.sv
// Reads back an active-low 7-segment bus, waits for it to settle,
// and hands the decoded digit out over a valid/ready interface.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       seg_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_digit,
    output logic       out_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        VALID,
        WAIT_CHG
    } state_t;

    localparam logic [CNT_W:0] TARGET =
        (CNT_W + 1)'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0] INC_ONE = (CNT_W + 1)'(1);
    localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

    if (STABLE_CYCLES < 1 ||
        STABLE_CYCLES > (1 << CNT_W) - 1) begin : g_cfg_err
        $error("seg7_capture: CNT_W cannot hold STABLE_CYCLES");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       cap_q, cap_d;
    logic             valid_q, valid_d;
    logic [2:0]       digit_q, digit_d;
    logic             err_q, err_d;
    logic             load_res;
    logic             changed;
    logic [CNT_W:0]   cnt_inc;
    logic [2:0]       dec_digit;
    logic             dec_err;

    assign changed = (seg_in != cap_q);
    assign cnt_inc = {1'b0, cnt_q} + INC_ONE;

    // Decode seg_in: whenever a result is loaded, the pattern
    // being captured equals seg_in on that edge.
    always_comb begin
        dec_digit = 3'd0;
        dec_err   = 1'b0;
        unique case (1'b1)
            (seg_in == 7'h01): dec_digit = 3'd0;
            (seg_in == 7'h4F): dec_digit = 3'd1;
            (seg_in == 7'h12): dec_digit = 3'd2;
            (seg_in == 7'h06): dec_digit = 3'd3;
            (seg_in == 7'h4C): dec_digit = 3'd4;
            (seg_in == 7'h24): dec_digit = 3'd5;
            (seg_in == 7'h20): dec_digit = 3'd6;
            (seg_in == 7'h0F): dec_digit = 3'd7;
            default:           dec_err   = 1'b1;
        endcase
    end

    // Next-state, capture/count and result register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        valid_d  = valid_q;
        digit_d  = digit_q;
        err_d    = err_q;
        load_res = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (seg_en) begin
                    cap_d    = seg_in;
                    cnt_d    = CNT_ONE;
                    state_d  = ONE_SHOT ? VALID : SETTLE;
                    load_res = ONE_SHOT;
                end
            end
            SETTLE: begin
                if (!seg_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cap_d = seg_in;
                    cnt_d = CNT_ONE;
                    if (ONE_SHOT) begin
                        state_d  = VALID;
                        load_res = 1'b1;
                    end
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                    if (cnt_inc >= TARGET) begin
                        state_d  = VALID;
                        load_res = 1'b1;
                    end
                end
            end
            VALID: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (seg_en && changed) begin
                        state_d = SETTLE;
                        cap_d   = seg_in;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = WAIT_CHG;
                    end
                end
            end
            WAIT_CHG: begin
                if (!seg_en) begin
                    state_d = IDLE;
                end else if (changed) begin
                    state_d = SETTLE;
                    cap_d   = seg_in;
                    cnt_d   = CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_res) begin
            valid_d = 1'b1;
            digit_d = dec_err ? 3'd0 : dec_digit;
            err_d   = dec_err;
        end
    end

    // State and output registers, cleared at once by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= 7'h7F;
            valid_q <= 1'b0;
            digit_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            digit_q <= digit_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_digit = digit_q;
    assign out_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus randomized
// traffic against a run-length reference model.
module tb_seg7_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic       seg_en = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid, out_err, busy;
    logic [2:0] out_digit;
    logic       v1, e1, b1;
    logic [2:0] d1;

    int n_checks = 0;
    int n_pass = 0;

    seg7_capture #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
        .seg_en(seg_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_digit(out_digit),
        .out_err(out_err), .busy(busy)
    );

    seg7_capture #(.STABLE_CYCLES(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
        .seg_en(seg_en), .out_valid(v1),
        .out_ready(out_ready), .out_digit(d1),
        .out_err(e1), .busy(b1)
    );

    always #5 clk = ~clk;

    // Reference model, index 0 = S=4 build, index 1 = S=1 build.
    // A result fires once a run of identical enabled samples
    // reaches S; after hand-off the same pattern is blocked.
    logic [6:0] legal [8] = '{7'h01, 7'h4F, 7'h12, 7'h06,
                              7'h4C, 7'h24, 7'h20, 7'h0F};
    int         m_s   [2] = '{4, 1};
    logic [6:0] m_val [2];
    int         m_len [2];
    bit         m_pend[2];
    bit         m_blk [2];
    logic [2:0] m_dig [2];
    bit         m_err [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 7'h7F; m_len[k] = 0;
            m_pend[k] = 0; m_blk[k] = 0;
            m_dig[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_edge(input bit en,
                              input logic [6:0] s,
                              input bit rdy);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_val[k] = 7'h7F; m_len[k] = 0;
                m_pend[k] = 0; m_blk[k] = 0;
                m_dig[k] = 0; m_err[k] = 0;
            end else if (m_pend[k]) begin
                if (rdy) begin
                    m_pend[k] = 0;
                    if (en && s != m_val[k]) begin
                        m_val[k] = s; m_len[k] = 1;
                    end else m_blk[k] = 1;
                end
            end else if (m_blk[k]) begin
                if (!en) begin
                    m_blk[k] = 0; m_len[k] = 0;
                end else if (s != m_val[k]) begin
                    m_blk[k] = 0; m_val[k] = s; m_len[k] = 1;
                end
            end else if (!en) begin
                m_len[k] = 0;
            end else begin
                if (m_len[k] == 0 || s != m_val[k]) begin
                    m_val[k] = s; m_len[k] = 1;
                end else m_len[k]++;
                if (m_len[k] >= m_s[k]) begin
                    m_pend[k] = 1; m_err[k] = 1; m_dig[k] = 0;
                    for (int i = 0; i < 8; i++)
                        if (legal[i] == m_val[k]) begin
                            m_dig[k] = 3'(i); m_err[k] = 0;
                        end
                end
            end
        end
    endtask

    task automatic step(input bit en, input logic [6:0] s,
                        input bit rdy);
        seg_en = en; seg_in = s; out_ready = rdy;
        @(posedge clk);
        model_edge(en, s, rdy);
        #1;
    endtask

    task automatic drain();
        step(0, 7'h7F, 1);
        step(0, 7'h7F, 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) step(1, 7'h12, 1);
        n_checks++;
        if ({out_valid, out_digit, out_err, busy} !== 6'b0)
            $display("FAIL reset_outs got %b exp 000000",
                     {out_valid, out_digit, out_err, busy});
        else n_pass++;
        n_checks++;
        if ({v1, d1, e1, b1} !== 6'b0)
            $display("FAIL reset_outs1 got %b exp 000000",
                     {v1, d1, e1, b1});
        else n_pass++;
        rst_n = 1'b1;
        step(0, 7'h7F, 0);
    endtask

    task automatic test_hold_digit();
        for (int i = 1; i <= 4; i++) begin
            step(1, 7'h12, 1);
            n_checks++;
            if (out_valid !== (i == 4))
                $display("FAIL hold_valid e%0d got %b exp %b",
                         i, out_valid, (i == 4));
            else n_pass++;
        end
        n_checks++;
        if (out_digit !== 3'd2 || out_err !== 1'b0)
            $display("FAIL hold_digit got %0d/%b exp 2/0",
                     out_digit, out_err);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step(1, 7'h12, 1);
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1)
                $display("FAIL hold_repeat got v=%b b=%b exp v=0 b=1",
                         out_valid, busy);
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        step(1, 7'h4F, 1);
        step(1, 7'h4F, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1, 7'h0F, 1);
            n_checks++;
            if (out_valid !== (i == 4))
                $display("FAIL restart_valid e%0d got %b exp %b",
                         i, out_valid, (i == 4));
            else n_pass++;
        end
        n_checks++;
        if (out_digit !== 3'd7)
            $display("FAIL restart_digit got %0d exp 7", out_digit);
        else n_pass++;
        drain();
    endtask

    task automatic test_blank();
        repeat (4) step(1, 7'h7F, 1);
        n_checks++;
        if ({out_valid, out_err, out_digit} !== 5'b11000)
            $display("FAIL blank_err got v=%b e=%b d=%0d exp 1/1/0",
                     out_valid, out_err, out_digit);
        else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        repeat (4) step(1, 7'h24, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 7'h01, 0);
            n_checks++;
            if ({out_valid, out_digit, out_err} !== 5'b11010)
                $display("FAIL bp_hold c%0d got v=%b d=%0d e=%b exp 1/5/0",
                         i, out_valid, out_digit, out_err);
            else n_pass++;
        end
        step(1, 7'h01, 1);
        for (int i = 2; i <= 4; i++) begin
            step(1, 7'h01, 0);
            n_checks++;
            if (out_valid !== (i == 4))
                $display("FAIL bp_next e%0d got %b exp %b",
                         i, out_valid, (i == 4));
            else n_pass++;
        end
        n_checks++;
        if (out_digit !== 3'd0 || out_err !== 1'b0)
            $display("FAIL bp_digit got %0d/%b exp 0/0",
                     out_digit, out_err);
        else n_pass++;
        drain();
    endtask

    task automatic test_rearm();
        repeat (4) step(1, 7'h06, 1);
        step(1, 7'h06, 1);
        step(0, 7'h06, 1);
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL rearm_idle got busy=%b exp 0", busy);
        else n_pass++;
        repeat (3) step(1, 7'h06, 1);
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL rearm_early got %b exp 0", out_valid);
        else n_pass++;
        step(1, 7'h06, 1);
        n_checks++;
        if (out_valid !== 1'b1 || out_digit !== 3'd3)
            $display("FAIL rearm_second got v=%b d=%0d exp 1/3",
                     out_valid, out_digit);
        else n_pass++;
        drain();
    endtask

    task automatic test_async_reset();
        repeat (3) step(1, 7'h12, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({out_valid, out_digit, out_err, busy} !== 6'b0)
            $display("FAIL arst_settle got %b exp 000000",
                     {out_valid, out_digit, out_err, busy});
        else n_pass++;
        step(1, 7'h12, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1, 7'h12, 0);
            n_checks++;
            if (out_valid !== (i == 4))
                $display("FAIL arst_resettle e%0d got %b exp %b",
                         i, out_valid, (i == 4));
            else n_pass++;
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({out_valid, out_digit, out_err, busy} !== 6'b0)
            $display("FAIL arst_valid got %b exp 000000",
                     {out_valid, out_digit, out_err, busy});
        else n_pass++;
        step(0, 7'h7F, 0);
        rst_n = 1'b1;
        repeat (3) step(0, 7'h7F, 1);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL arst_stale got v=%b b=%b exp 0/0",
                     out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_one_shot();
        step(1, 7'h4C, 0);
        n_checks++;
        if (v1 !== 1'b1 || d1 !== 3'd4 || e1 !== 1'b0)
            $display("FAIL oneshot got v=%b d=%0d e=%b exp 1/4/0",
                     v1, d1, e1);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL oneshot_s4 got %b exp 0", out_valid);
        else n_pass++;
        drain();
        drain();
    endtask

    task automatic test_random();
        logic [6:0] s;
        bit         en, rdy;
        int         r;
        s = 7'h01;
        for (int n = 0; n < 600; n++) begin
            en = ($urandom_range(0, 11) != 0);
            r  = int'($urandom_range(0, 9));
            if (r == 7)
                s = legal[$urandom_range(0, 7)];
            else if (r == 8)
                s = 7'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            step(en, s, rdy);
            for (int k = 0; k < 2; k++) begin
                logic v, b, e;
                logic [2:0] d;
                v = k == 0 ? out_valid : v1;
                b = k == 0 ? busy : b1;
                e = k == 0 ? out_err : e1;
                d = k == 0 ? out_digit : d1;
                n_checks++;
                if (v !== m_pend[k] || b !==
                    (m_pend[k] || m_blk[k] || m_len[k] > 0))
                    $display("FAIL rnd_vb n%0d k%0d got %b%b exp %b%b",
                             n, k, v, b, m_pend[k],
                             (m_pend[k] || m_blk[k] || m_len[k] > 0));
                else n_pass++;
                if (m_pend[k]) begin
                    n_checks++;
                    if (d !== m_dig[k] || e !== m_err[k])
                        $display("FAIL rnd_res n%0d k%0d got %0d/%b exp %0d/%b",
                                 n, k, d, e, m_dig[k], m_err[k]);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_digit();
        drain();
        test_restart();
        test_blank();
        test_backpressure();
        test_rearm();
        test_async_reset();
        test_one_shot();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
